// File: rtl/bcd_ascii_tx.sv
// bcd_ascii_tx: latches an N-digit BCD count and streams it out as an
// ASCII line (digits, optional '+', CR, LF) over a valid/ready byte port.
module bcd_ascii_tx #(
    parameter int Ndigit         = 3,
    parameter bit SUPPRESS_ZEROS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [Ndigit*4-1:0]   BCD,
    input  logic                  overflow,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (Ndigit > 1) ? $clog2(Ndigit) : 1;

    typedef enum logic [2:0] {IDLE, DIGIT, OVF, CR, LF} state_t;

    state_t                state_q;
    logic [Ndigit*4-1:0]   bcd_q;
    logic                  ovf_q;
    logic [IW-1:0]         idx_q;
    logic                  lz_q;
    logic [7:0]            data_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [3:0]            cur_d;
    logic [3:0]            nxt_d;
    logic                  lz_d;

    function automatic logic [7:0] dig_byte(input logic [3:0] d,
                                            input logic       lz,
                                            input logic       last);
        if (d > 4'd9)
            return 8'h3F;
        if (SUPPRESS_ZEROS && lz && (d == 4'd0) && !last)
            return 8'h20;
        return {4'h3, d};
    endfunction

    always_comb begin
        cur_d = 4'd0;
        nxt_d = 4'd0;
        for (int k = 0; k < Ndigit; k++) begin
            if (k == int'(idx_q))
                cur_d = bcd_q[k*4 +: 4];
            if (k == int'(idx_q) - 1)
                nxt_d = bcd_q[k*4 +: 4];
        end
        lz_d = lz_q && (cur_d == 4'd0);
    end

    // tx_valid is high in every non-IDLE state, so tx_ready alone marks a transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            lz_q    <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bcd_q   <= BCD;
                        ovf_q   <= overflow;
                        idx_q   <= IW'(Ndigit - 1);
                        lz_q    <= 1'b1;
                        data_q  <= dig_byte(BCD[(Ndigit-1)*4 +: 4], 1'b1,
                                            Ndigit == 1);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (tx_ready) begin
                        lz_q <= lz_d;
                        if (idx_q != '0) begin
                            idx_q  <= idx_q - IW'(1);
                            data_q <= dig_byte(nxt_d, lz_d, idx_q == IW'(1));
                        end else if (ovf_q) begin
                            data_q  <= 8'h2B;
                            state_q <= OVF;
                        end else begin
                            data_q  <= 8'h0D;
                            state_q <= CR;
                        end
                    end
                end
                OVF: begin
                    if (tx_ready) begin
                        data_q  <= 8'h0D;
                        state_q <= CR;
                    end
                end
                CR: begin
                    if (tx_ready) begin
                        data_q  <= 8'h0A;
                        state_q <= LF;
                    end
                end
                LF: begin
                    if (tx_ready) begin
                        data_q  <= 8'h00;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Bench for bcd_ascii_tx: vector table plus hand sequences, byte stream
// checked against a scoreboard queue per DUT instance.
module tb_bcd_ascii_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd;
    logic        ovf;
    logic        st  [2];
    logic        rdy [2];
    logic [7:0]  txd [2];
    logic        txv [2];
    logic        bsy [2];
    logic        dn  [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    logic       stall_q [2];
    logic [7:0] pd_q    [2];

    typedef struct {
        bit              sz;
        logic [11:0]     bcd;
        logic            ovf;
        int              len;
        logic [0:5][7:0] b;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    // index 0: leading zeros printed, index 1: leading zeros suppressed
    bcd_ascii_tx #(.Ndigit(3), .SUPPRESS_ZEROS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .BCD(bcd), .overflow(ovf),
        .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(rdy[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    bcd_ascii_tx #(.Ndigit(3), .SUPPRESS_ZEROS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .BCD(bcd), .overflow(ovf),
        .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(rdy[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                if (stall_q[i]) begin
                    chk($sformatf("hold_valid%0d", i), int'(txv[i]), 1);
                    chk($sformatf("hold_data%0d", i), int'(txd[i]), int'(pd_q[i]));
                end
                chk($sformatf("valid_idle%0d", i), int'(txv[i] && !bsy[i]), 0);
                if (txv[i] && rdy[i]) begin
                    if ((i == 1 && q1.size() == 0) || (i == 0 && q0.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte%0d got %0h required none", i, txd[i]);
                    end else if (i == 1) begin
                        chk("byte1", int'(txd[1]), int'(q1.pop_front()));
                    end else begin
                        chk("byte0", int'(txd[0]), int'(q0.pop_front()));
                    end
                end
            end
            stall_q[i] = rst && txv[i] && !rdy[i];
            pd_q[i]    = txd[i];
        end
    end

    function automatic int qsize(int s);
        return (s == 1) ? q1.size() : q0.size();
    endfunction

    task automatic push_line(int s, vec_t v);
        for (int b = 0; b < v.len; b++) begin
            if (s == 1) q1.push_back(v.b[b]);
            else        q0.push_back(v.b[b]);
        end
    endtask

    // leaves the bench in the cycle where done is high
    task automatic run_vec(vec_t v, string nm);
        int s;
        int cyc;
        s = v.sz ? 1 : 0;
        push_line(s, v);
        bcd    = v.bcd;
        ovf    = v.ovf;
        rdy[s] = 1'b1;
        st[s]  = 1'b1;
        @(posedge clk); #1;
        st[s] = 1'b0;
        bcd   = 12'($urandom);
        ovf   = 1'($urandom);
        chk({nm, "_busy"}, int'(bsy[s]), 1);
        cyc = 0;
        while (!dn[s] && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_len"}, cyc, v.len);
        chk({nm, "_idle"}, int'(bsy[s]), 0);
        chk({nm, "_left"}, qsize(s), 0);
    endtask

    initial begin
        vec_t v;
        int   cyc;
        vt[0] = '{1'b1, 12'h042, 1'b0, 5, {8'h20, 8'h34, 8'h32, 8'h0D, 8'h0A, 8'h00}};
        vt[1] = '{1'b1, 12'h000, 1'b0, 5, {8'h20, 8'h20, 8'h30, 8'h0D, 8'h0A, 8'h00}};
        vt[2] = '{1'b0, 12'h000, 1'b0, 5, {8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h00}};
        vt[3] = '{1'b1, 12'h999, 1'b1, 6, {8'h39, 8'h39, 8'h39, 8'h2B, 8'h0D, 8'h0A}};
        vt[4] = '{1'b1, 12'h1A5, 1'b0, 5, {8'h31, 8'h3F, 8'h35, 8'h0D, 8'h0A, 8'h00}};
        vt[5] = '{1'b1, 12'h0A0, 1'b0, 5, {8'h20, 8'h3F, 8'h30, 8'h0D, 8'h0A, 8'h00}};
        vt[6] = '{1'b0, 12'h042, 1'b0, 5, {8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A, 8'h00}};
        vt[7] = '{1'b1, 12'h100, 1'b1, 6, {8'h31, 8'h30, 8'h30, 8'h2B, 8'h0D, 8'h0A}};
        vt[8] = '{1'b1, 12'h00F, 1'b0, 5, {8'h20, 8'h20, 8'h3F, 8'h0D, 8'h0A, 8'h00}};
        vt[9] = '{1'b1, 12'h005, 1'b0, 5, {8'h20, 8'h20, 8'h35, 8'h0D, 8'h0A, 8'h00}};

        st[0] = 0; st[1] = 0; rdy[0] = 1; rdy[1] = 1;
        bcd = '0; ovf = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_data", int'(txd[1]), 0);
        chk("rst_valid", int'(txv[1]), 0);
        chk("rst_busy", int'(bsy[1]), 0);
        chk("rst_done", int'(dn[1]), 0);
        chk("rst_valid0", int'(txv[0]), 0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // consecutive vectors on one instance start in the done cycle
        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
            if (i % 3 == 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk("done_pulse", int'(dn[1]), 0);

        // backpressure, BCD churn and ignored starts
        v = '{1'b1, 12'h307, 1'b0, 5, {8'h33, 8'h30, 8'h37, 8'h0D, 8'h0A, 8'h00}};
        push_line(1, v);
        bcd    = 12'h307;
        ovf    = 1'b0;
        rdy[1] = 1'($urandom);
        st[1]  = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        cyc = 0;
        while (!dn[1] && cyc < 300) begin
            rdy[1] = 1'($urandom_range(0, 1));
            bcd    = 12'($urandom);
            ovf    = 1'($urandom);
            st[1]  = bsy[1] && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            cyc++;
        end
        st[1] = 1'b0;
        chk("bp_done", int'(cyc < 300), 1);
        chk("bp_left", qsize(1), 0);
        rdy[1] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_no_extra", int'(bsy[1]), 0);
        end

        // asynchronous reset after the second byte of a line
        v = '{1'b1, 12'h456, 1'b0, 2, {8'h34, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00}};
        push_line(1, v);
        bcd   = 12'h456;
        st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("ar_valid", int'(txv[1]), 0);
        chk("ar_busy", int'(bsy[1]), 0);
        chk("ar_done", int'(dn[1]), 0);
        chk("ar_data", int'(txd[1]), 0);
        chk("ar_left", qsize(1), 0);
        #10 rst = 1'b1;
        @(posedge clk); #1;
        chk("ar_no_resume", int'(txv[1]), 0);
        v = '{1'b1, 12'h123, 1'b0, 5, {8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A, 8'h00}};
        run_vec(v, "after_rst");
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_ascii_tx.md
# bcd_ascii_tx

Serialises a latched N-digit BCD count into an ASCII text line (digits, optional overflow marker, CR, LF) for the UART transmitter. It sits between the N-digit BCD counter and the UART TX byte interface in the dark-counter readout path. The block converts the counter's parallel BCD word into the byte stream a host terminal reads. It uses a valid/ready byte handshake, so it tolerates any UART baud rate.

## Interface

Parameters:
- Ndigit, 3: number of BCD digits on `BCD`.
- SUPPRESS_ZEROS, 1: 1 replaces leading zero digits with spaces; 0 prints all digits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state immediately when 0.
- start  input  1  one-cycle request to latch `BCD`/`overflow` and send one line.
- BCD  input  Ndigit*4  count value; digit k occupies bits [4k+3:4k], digit Ndigit-1 is most significant.
- overflow  input  1  counter roll-over flag, latched together with `BCD`.
- tx_data  output  8  ASCII byte offered to the UART TX.
- tx_valid  output  1  `tx_data` holds a byte to transfer.
- tx_ready  input  1  UART TX accepts the byte this cycle.
- busy  output  1  a line is in progress; `start` is ignored while high.
- done  output  1  one-cycle pulse after the LF byte is transferred.

## Operation

- States: IDLE, DIGIT, OVF, CR, LF.
  - A transfer is a rising edge with `tx_valid` and `tx_ready` both high.
  - The state only advances on a transfer.
- IDLE, `start`=1:
  - Latch `BCD` into a shadow register and `overflow` into `ovf_q`.
  - Set digit index = Ndigit-1 and the leading-zero flag `lz` = 1.
  - Go to DIGIT; `busy` = 1.
- DIGIT, byte at current index d:
  - If d > 9: send 0x3F ('?').
  - Else if SUPPRESS_ZEROS=1, `lz`=1, d=0 and index ≠ 0: send 0x20 (space).
  - Else: send 0x30+d.
  - `lz` clears on the first transferred digit that is nonzero or invalid.
  - The least significant digit is never suppressed.
  - On transfer: if index>0, decrement index; else go to OVF if `ovf_q`=1, otherwise to CR.
- OVF: send 0x2B ('+'); on transfer go to CR.
- CR: send 0x0D; on transfer go to LF.
- LF: send 0x0A; on transfer go to IDLE, pulse `done`, drop `busy`.
- Line length L = Ndigit + `ovf_q` + 2 bytes.
- Inputs `BCD`/`overflow` are don't-care after the latch cycle.
- `start` while `busy`=1 is ignored and not queued.
- `start` in the same cycle `done` is high is accepted.
- Reset mid-line: all outputs clear asynchronously; the line is abandoned and not resumed. The next `start` sends a complete line.

## Timing

- Reset values: `tx_data`=0x00, `tx_valid`=0, `busy`=0, `done`=0, state IDLE.
- All outputs are registered.
- `start` sampled at edge 0: `busy` and `tx_valid` are high from edge 0, with the first digit on `tx_data`.
- With `tx_ready` held high: one byte per cycle. Transfers occur at edges 1..L; `done`=1 and `busy`=0 after edge L.
- `tx_valid` stays high and `tx_data` stays stable while `tx_ready`=0. No bubble between bytes of a line.
- `tx_valid` is 0 whenever `busy` is 0.

## Test plan

- Ndigit=3, SUPPRESS_ZEROS=1, `BCD`=0x042, `overflow`=0, `tx_ready`=1, start pulse:
  - Bytes 0x20,0x34,0x32,0x0D,0x0A at edges 1-5.
  - `done` high for exactly the cycle after edge 5.
- `BCD`=0x000: bytes 0x20,0x20,0x30,0x0D,0x0A. With SUPPRESS_ZEROS=0: 0x30,0x30,0x30,0x0D,0x0A.
- `BCD`=0x999, `overflow`=1: bytes 0x39,0x39,0x39,0x2B,0x0D,0x0A; `done` after edge 6.
- `BCD`=0x1A5: bytes 0x31,0x3F,0x35,0x0D,0x0A. `BCD`=0x0A0: bytes 0x20,0x3F,0x30,0x0D,0x0A.
- Backpressure, `BCD`=0x307:
  - Randomly toggle `tx_ready` and change `BCD` every cycle after start.
  - Required: byte sequence 0x33,0x30,0x37,0x0D,0x0A; `tx_data` stable while `tx_valid`=1 and `tx_ready`=0.
  - Extra `start` pulses while `busy`=1 produce no additional line.
- Drive `rst`=0 between clock edges after the second byte of a line: `tx_valid`, `busy` and `done` go 0 before the next edge. After release, start with `BCD`=0x123 gives 0x31,0x32,0x33,0x0D,0x0A.
